// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA modular-exponentiation scheduler.
package rsa_pkg;

   typedef enum logic [2:0] {IDLE, ISSUE, BUSY, HOLD, RESP} state_t;

   localparam int unsigned PORT_ENC      = 0;
   localparam int unsigned PORT_DEC      = 1;
   localparam int unsigned FIXED_LAT_DEF = 64;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; on a tie the grant goes to the port not granted last.
module rr_arb2
   import rsa_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] valid,
   input  logic       enable,
   output logic [1:0] grant
);

   logic last_grant_q;
   logic last_grant_d;

   always_comb begin
      grant = '0;
      if (valid[PORT_ENC] && valid[PORT_DEC]) begin
         if (last_grant_q) grant[PORT_ENC] = 1'b1;
         else              grant[PORT_DEC] = 1'b1;
      end else begin
         grant = valid;
      end

      last_grant_d = last_grant_q;
      if (enable && (grant != '0)) last_grant_d = grant[PORT_DEC];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_grant_q <= 1'b1;
      else        last_grant_q <= last_grant_d;
   end

endmodule

// File: rtl/rsa_modexp_sched.sv
// Shares one modexp engine between the encrypt and decrypt ports, with optional
// constant-time padding of the response to FIXED_LAT cycles after ISSUE.
module rsa_modexp_sched
   import rsa_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned FIXED_LAT = FIXED_LAT_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               const_time,
   input  logic               req0_valid,
   output logic               req0_ready,
   input  logic [2*WIDTH-1:0] req0_base,
   input  logic [2*WIDTH-1:0] req0_exp,
   input  logic [2*WIDTH-1:0] req0_mod,
   input  logic               req1_valid,
   output logic               req1_ready,
   input  logic [2*WIDTH-1:0] req1_base,
   input  logic [2*WIDTH-1:0] req1_exp,
   input  logic [2*WIDTH-1:0] req1_mod,
   output logic               rsp0_valid,
   output logic [2*WIDTH-1:0] rsp0_data,
   output logic               rsp0_err,
   output logic               rsp1_valid,
   output logic [2*WIDTH-1:0] rsp1_data,
   output logic               rsp1_err,
   output logic               eng_start,
   output logic [2*WIDTH-1:0] eng_base,
   output logic [2*WIDTH-1:0] eng_exp,
   output logic [2*WIDTH-1:0] eng_mod,
   input  logic               eng_done,
   input  logic [2*WIDTH-1:0] eng_result,
   output logic               overrun
);

   localparam int unsigned DW     = 2 * WIDTH;
   localparam logic [15:0] LAT    = 16'(FIXED_LAT);
   localparam logic [15:0] LAT_M1 = 16'(FIXED_LAT - 1);

   state_t        state_q, state_d;
   logic          port_q, port_d;
   logic          ct_q, ct_d;
   logic          err_q, err_d;
   logic          overrun_q, overrun_d;
   logic [DW-1:0] base_q, base_d, exp_q, exp_d, mod_q, mod_d;
   logic [DW-1:0] res_q, res_d, data0_q, data0_d, data1_q, data1_d;
   logic [15:0]   cyc_q, cyc_d, cyc_inc;
   logic [1:0]    grant;
   logic          accept, mod_small, done;

   rr_arb2 u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .valid  ({req1_valid, req0_valid}),
      .enable (state_q == IDLE),
      .grant  (grant)
   );

   assign accept    = (state_q == IDLE) && (grant != '0);
   assign mod_small = (mod_q[DW-1:1] == '0);
   assign done      = mod_small || eng_done;
   assign cyc_inc   = (cyc_q == 16'hFFFF) ? cyc_q : cyc_q + 16'd1;

   // cyc is zeroed on acceptance so it reads k in the k-th cycle after ISSUE;
   // HOLD exits at FIXED_LAT-1 so RESP lands exactly at cyc == FIXED_LAT.
   always_comb begin
      state_d   = state_q;
      port_d    = port_q;
      ct_d      = ct_q;
      base_d    = base_q;
      exp_d     = exp_q;
      mod_d     = mod_q;
      res_d     = res_q;
      err_d     = err_q;
      cyc_d     = cyc_q;
      overrun_d = overrun_q;
      data0_d   = data0_q;
      data1_d   = data1_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               port_d  = grant[PORT_DEC];
               base_d  = grant[PORT_DEC] ? req1_base : req0_base;
               exp_d   = grant[PORT_DEC] ? req1_exp  : req0_exp;
               mod_d   = grant[PORT_DEC] ? req1_mod  : req0_mod;
               ct_d    = const_time;
               cyc_d   = '0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            cyc_d   = cyc_inc;
            res_d   = '0;
            err_d   = mod_small;
            state_d = BUSY;
         end
         BUSY: begin
            cyc_d = cyc_inc;
            if (eng_done && !mod_small) begin
               res_d = eng_result;
               err_d = 1'b0;
            end
            if (done) begin
               if (!ct_q || (cyc_q >= LAT_M1)) state_d = RESP;
               else                            state_d = HOLD;
            end else if (ct_q && (cyc_q >= LAT)) begin
               overrun_d = 1'b1;
            end
         end
         HOLD: begin
            cyc_d = cyc_inc;
            if (cyc_q >= LAT_M1) state_d = RESP;
         end
         RESP: begin
            if (port_q) data1_d = res_q;
            else        data0_d = res_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         port_q    <= 1'b0;
         ct_q      <= 1'b0;
         err_q     <= 1'b0;
         overrun_q <= 1'b0;
         base_q    <= '0;
         exp_q     <= '0;
         mod_q     <= '0;
         res_q     <= '0;
         data0_q   <= '0;
         data1_q   <= '0;
         cyc_q     <= '0;
      end else begin
         state_q   <= state_d;
         port_q    <= port_d;
         ct_q      <= ct_d;
         err_q     <= err_d;
         overrun_q <= overrun_d;
         base_q    <= base_d;
         exp_q     <= exp_d;
         mod_q     <= mod_d;
         res_q     <= res_d;
         data0_q   <= data0_d;
         data1_q   <= data1_d;
         cyc_q     <= cyc_d;
      end
   end

   assign req0_ready = (state_q == IDLE) && grant[PORT_ENC];
   assign req1_ready = (state_q == IDLE) && grant[PORT_DEC];
   assign rsp0_valid = (state_q == RESP) && !port_q;
   assign rsp1_valid = (state_q == RESP) && port_q;
   assign rsp0_data  = rsp0_valid ? res_q : data0_q;
   assign rsp1_data  = rsp1_valid ? res_q : data1_q;
   assign rsp0_err   = rsp0_valid && err_q;
   assign rsp1_err   = rsp1_valid && err_q;
   assign eng_start  = (state_q == ISSUE) && !mod_small;
   assign eng_base   = base_q;
   assign eng_exp    = exp_q;
   assign eng_mod    = mod_q;
   assign overrun    = overrun_q;

endmodule

// File: doc/rsa_modexp_sched.md
# rsa_modexp_sched

Scheduler that shares one modular-exponentiation engine between two requesters (port 0 = encrypt path, port 1 = decrypt path) in the RSA pipeline. It runs round-robin arbitration, latches operands, sequences the engine start/done handshake, and routes the result back to the granted port. An optional constant-time mode pads every operation to a fixed latency so response timing does not leak the exponent.

## Interface
- WIDTH, 8: half-width of RSA operands; datapath operands are 2*WIDTH bits.
- FIXED_LAT, 64: constant-time response cycle count, measured from the ISSUE cycle; legal range 2..65535.
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- const_time  in  1  padding enable; sampled at grant.
- req0_valid / req1_valid  in  1  request pending.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- req0_base, req0_exp, req0_mod / req1_* (same)  in  2*WIDTH each  operands; must hold while valid and not ready.
- rsp0_valid / rsp1_valid  out  1  one-cycle result pulse.
- rsp0_data / rsp1_data  out  2*WIDTH  result; held until that port's next response.
- rsp0_err / rsp1_err  out  1  qualified by rspN_valid; set when mod < 2.
- eng_start  out  1  one-cycle engine start pulse.
- eng_base, eng_exp, eng_mod  out  2*WIDTH  operand registers; stable from ISSUE until the return to IDLE.
- eng_done  in  1  engine completion pulse.
- eng_result  in  2*WIDTH  valid with eng_done.
- overrun  out  1  sticky; set when the engine exceeds FIXED_LAT in constant-time mode. Cleared only by reset.

## Operation
- States: IDLE, ISSUE, BUSY, HOLD, RESP.
- IDLE: the grant goes to the single valid port. If both ports are valid, the grant goes to the port other than last_grant. last_grant resets to 1, so port 0 wins the first tie.
  - reqN_ready = (state==IDLE) & grantN, combinational.
  - On valid&ready: latch operands, latch const_time into ct_q, update last_grant, go to ISSUE.
- ISSUE:
  - Clear cyc to 0.
  - If mod ≥ 2: assert eng_start.
  - If mod < 2: no engine start; set res_q=0 and err_q=1.
  - Go to BUSY.
- BUSY: cyc increments every cycle, 16-bit, saturating.
  - If mod < 2, the result is already known and the done event is treated as occurring immediately.
  - On eng_done: capture eng_result into res_q with err_q=0.
  - When done and ct_q=0: go to RESP.
  - When done and ct_q=1: go to HOLD.
  - If ct_q=1 and cyc reaches FIXED_LAT without done: set overrun, remain in BUSY, and go to RESP on the cycle after eng_done.
- HOLD: wait until cyc == FIXED_LAT-1, then go to RESP. This places rsp_valid exactly at cyc == FIXED_LAT.
- RESP:
  - Pulse rspN_valid for the granted port.
  - Drive rspN_data=res_q and rspN_err=err_q for that port.
  - Go to IDLE.
- eng_done outside BUSY is ignored.
- Reset values:
  - All outputs 0 and all registers 0.
  - state=IDLE, last_grant=1.
  - Reset mid-operation abandons the operation; no response is issued.

## Timing
- Acceptance: cycle A, the IDLE cycle where valid&ready.
- ISSUE: cycle A+1; eng_start is high in A+1 only.
- Non-constant-time mode: eng_done at cycle D (D ≥ A+2) gives rsp_valid at D+1.
  - mod < 2 case: rsp_valid at A+3.
- Constant-time mode: rsp_valid at A+1+FIXED_LAT whenever done arrives by then, including the mod < 2 case.
- Back-to-back: the next acceptance can occur in the cycle after RESP. Minimum issue-to-issue spacing is 4 cycles.
- req*_ready is never high outside IDLE; requests arriving during service wait.

## Structure
- Shared package rsa_pkg:
  - state enum (IDLE, ISSUE, BUSY, HOLD, RESP).
  - Port index constants PORT_ENC=0, PORT_DEC=1.
  - Default FIXED_LAT.
- Sub-module rr_arb2:
  - 2-way round-robin arbiter with inputs valid[1:0], enable, and last_grant register.
  - Output is a one-hot grant.
- The top level holds the FSM, operand/result registers, the cycle counter and the overrun flag.

## Test plan
- Single port-0 request, base=5, exp=3, mod=33, const_time=0; engine model returns 26 at A+5 → rsp0_valid at A+6, rsp0_data=26, rsp0_err=0, rsp1 silent.
- req0 and req1 both valid after reset → port 0 granted first, port 1 granted in the IDLE cycle after port 0's RESP. Repeat with both held valid → strict alternation 0,1,0,1.
- const_time=1, FIXED_LAT=20, engine latency varied over 3, 10 and 18 cycles → rsp_valid always at A+21; overrun stays 0.
- const_time=1, FIXED_LAT=8, engine latency 12 → overrun=1, response the cycle after eng_done with correct data; overrun stays 1 on later requests.
- mod=1 with const_time=0 → no eng_start, rsp at A+3, data=0, err=1. Same stimulus with const_time=1 → response at A+1+FIXED_LAT.
- rst_n asserted while in BUSY → all outputs 0 immediately, no rsp pulse. After release, a new request completes normally with port 0 winning the first tie.
